// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared constants and state encoding for the serial BCD subtractor.
//   DIGIT_W   : bits per BCD digit
//   BCD_MAX   : largest legal digit value
//   BCD_RADIX : decimal radix, used when a digit subtraction borrows
//   state_t   : controller states IDLE / SUB / NEGATE / DONE
// Optional feature macro: BCD_SIGNED_RESULT_EN (see bcd_serial_subtractor.sv).
package bcd_pkg;
    localparam int DIGIT_W   = 4;
    localparam int BCD_MAX   = 9;
    localparam int BCD_RADIX = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SUB    = 2'd1,
        NEGATE = 2'd2,
        DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/bcd_digit_sub.sv
// Combinational single-digit BCD subtract cell: d = x - y - bi (mod 10).
//   x, y : BCD digits (minuend, subtrahend)
//   bi   : borrow in
//   d    : result digit
//   bo   : borrow out
//   bad  : either input digit is above 9
module bcd_digit_sub
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] x,
    input  logic [DIGIT_W-1:0] y,
    input  logic               bi,
    output logic [DIGIT_W-1:0] d,
    output logic               bo,
    output logic               bad
);
    // One extra bit holds the sign; the range -16..15 fits exactly.
    logic [DIGIT_W:0] t;

    always_comb begin
        t   = {1'b0, x} - {1'b0, y} - {{DIGIT_W{1'b0}}, bi};
        bo  = t[DIGIT_W];
        // Adding the radix modulo 16 equals (t + 10) truncated to 4 bits.
        d   = bo ? (t[DIGIT_W-1:0] + DIGIT_W'(BCD_RADIX)) : t[DIGIT_W-1:0];
        bad = (x > DIGIT_W'(BCD_MAX)) || (y > DIGIT_W'(BCD_MAX));
    end
endmodule

// File: rtl/bcd_serial_subtractor.sv
// Multi-digit BCD subtractor, diff = a - b - bin, one digit per clock, LSD first.
// A single bcd_digit_sub cell is shared by the subtract and negate passes.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, sampled only in IDLE
//   a, b     : packed BCD operands, digit 0 in bits [3:0]
//   bin      : borrow in
//   busy     : high in SUB and NEGATE
//   done     : one-cycle pulse, results valid
//   diff     : packed BCD result
//   bout     : borrow out of the most significant digit
//   neg      : result negative
//   err      : some input digit was above 9 (computation still completes)
// Macro BCD_SIGNED_RESULT_EN: a negative result is converted to its magnitude
// by a second pass computing 0 - diff; otherwise diff is the 10's complement.
module bcd_serial_subtractor
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                    bin,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] diff,
    output logic                    bout,
    output logic                    neg,
    output logic                    err
);
    localparam int W  = DIGIT_W * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t          state, state_nx;
    logic [W-1:0]    sa, sb, acc, acc_nx;
    logic [IW-1:0]   idx;
    logic            brw, err_acc, last;
    logic [DIGIT_W-1:0] cx, cd;
    logic            cbo, cbad;

    // The negate pass subtracts the partial result from zero.
    assign cx     = (state == NEGATE) ? '0 : sa[DIGIT_W-1:0];
    assign last   = (idx == IW'(DIGITS - 1));
    // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom.
    assign acc_nx = W'({cd, acc} >> DIGIT_W);

    bcd_digit_sub u_cell (
        .x   (cx),
        .y   (sb[DIGIT_W-1:0]),
        .bi  (brw),
        .d   (cd),
        .bo  (cbo),
        .bad (cbad)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:   if (start) state_nx = SUB;
            SUB:    if (last) begin
`ifdef BCD_SIGNED_RESULT_EN
                        state_nx = cbo ? NEGATE : DONE;
`else
                        state_nx = DONE;
`endif
                    end
            NEGATE: if (last) state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state == SUB) || (state == NEGATE);
        done = (state == DONE);
    end

    // Datapath: operand shifters, borrow chain, index, result register
    always_ff @(posedge clk) begin
        if (rst) begin
            sa      <= '0;
            sb      <= '0;
            acc     <= '0;
            idx     <= '0;
            brw     <= 1'b0;
            err_acc <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            neg     <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    sa      <= a;
                    sb      <= b;
                    brw     <= bin;
                    idx     <= '0;
                    err_acc <= 1'b0;
                end
                SUB: begin
                    sa      <= sa >> DIGIT_W;
                    sb      <= sb >> DIGIT_W;
                    brw     <= cbo;
                    acc     <= acc_nx;
                    err_acc <= err_acc | cbad;
                    idx     <= idx + IW'(1);
                    if (last) begin
`ifdef BCD_SIGNED_RESULT_EN
                        if (cbo) begin
                            // Re-feed the 10's-complement result as subtrahend of 0.
                            sb  <= acc_nx;
                            brw <= 1'b0;
                            idx <= '0;
                        end else begin
                            diff <= acc_nx;
                            bout <= 1'b0;
                            neg  <= 1'b0;
                            err  <= err_acc | cbad;
                        end
`else
                        diff <= acc_nx;
                        bout <= cbo;
                        neg  <= cbo;
                        err  <= err_acc | cbad;
`endif
                    end
                end
                NEGATE: begin
                    sb  <= sb >> DIGIT_W;
                    brw <= cbo;
                    acc <= acc_nx;
                    idx <= idx + IW'(1);
                    if (last) begin
                        diff <= acc_nx;
                        bout <= 1'b1;
                        neg  <= 1'b1;
                        err  <= err_acc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_serial_subtractor.sv
module tb_bcd_serial_subtractor;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst, start, bin;
    logic [W-1:0] a, b;
    logic         busy, done, bout, neg, err;
    logic [W-1:0] diff;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bcd_serial_subtractor #(.DIGITS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .diff(diff), .bout(bout), .neg(neg), .err(err)
    );

    function automatic int bcd2int(input logic [W-1:0] v);
        int r = 0;
        for (int i = N - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r = '0;
        for (int i = 0; i < N; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference: plain integer arithmetic on decimal values.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbi,
                                  output logic [W-1:0] d, output logic bo, output logic ng,
                                  output int lat);
        int p = 1;
        int v;
        for (int i = 0; i < N; i++) p = p * 10;
        v = bcd2int(ma) - bcd2int(mb) - int'(mbi);
        if (v >= 0) begin
            d = int2bcd(v); bo = 1'b0; ng = 1'b0; lat = N + 1;
        end else begin
`ifdef BCD_SIGNED_RESULT_EN
            d = int2bcd((-v) % p); lat = 2 * N + 1;
`else
            d = int2bcd(v + p); lat = N + 1;
`endif
            bo = 1'b1; ng = 1'b1;
        end
    endfunction

    // Issue one op from IDLE; returns latency (cycles after the start edge) and captured outputs.
    // Entry/exit: #1 after a rising edge.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tbi,
                          output int lat, output logic [W-1:0] d, output logic bo,
                          output logic ng, output logic er, output logic busy_ok);
        a = ta; b = tb_; bin = tbi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; busy_ok = 1'b1; d = 'x; bo = 1'bx; ng = 1'bx; er = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c; d = diff; bo = bout; ng = neg; er = err;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                            input logic tbi, input logic exp_err);
        int lat, elat;
        logic [W-1:0] d, ed;
        logic bo, ng, er, bok, ebo, eng;
        model(ta, tb_, tbi, ed, ebo, eng, elat);
        run_op(ta, tb_, tbi, lat, d, bo, ng, er, bok);
        total++;
        if ({8'(lat), d, bo, ng, er, bok} !== {8'(elat), ed, ebo, eng, exp_err, 1'b1})
            $display("FAIL %s a=%h b=%h bin=%b: got lat=%0d diff=%h bout=%b neg=%b err=%b busy_ok=%b, want lat=%0d diff=%h bout=%b neg=%b err=%b busy_ok=1",
                     name, ta, tb_, tbi, lat, d, bo, ng, er, bok, elat, ed, ebo, eng, exp_err);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, diff, bout, neg, err} !== '0)
            $display("FAIL reset: got busy=%b done=%b diff=%h bout=%b neg=%b err=%b, want all 0",
                     busy, done, diff, bout, neg, err);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        check_op("basic",        16'h0042, 16'h0017, 1'b0, 1'b0);
        check_op("negative",     16'h0017, 16'h0042, 1'b0, 1'b0);
        check_op("ripple",       16'h1000, 16'h0001, 1'b0, 1'b0);
        check_op("zero_bin",     16'h0000, 16'h0000, 1'b1, 1'b0);
        check_op("zero_zero",    16'h0000, 16'h0000, 1'b0, 1'b0);
        check_op("max_minus",    16'h9999, 16'h9999, 1'b1, 1'b0);
        check_op("min_minus_max",16'h0000, 16'h9999, 1'b0, 1'b0);
    endtask

    task automatic test_hold();
        logic [W-1:0] d0;
        check_op("hold_op", 16'h0017, 16'h0042, 1'b0, 1'b0);
        d0 = diff;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({done, busy, diff} !== {2'b00, d0})
            $display("FAIL hold: got done=%b busy=%b diff=%h, want done=0 busy=0 diff=%h", done, busy, diff, d0);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_err();
        int lat;
        logic [W-1:0] d;
        logic bo, ng, er, bok;
        run_op(16'h004A, 16'h0001, 1'b0, lat, d, bo, ng, er, bok);
        total++;
        // Digit 0: 10-1 = 9, no borrow; remaining digits 004.
        if ({8'(lat), d, bo, ng, er} !== {8'(N + 1), 16'h0049, 1'b0, 1'b0, 1'b1})
            $display("FAIL err_digit: got lat=%0d diff=%h bout=%b neg=%b err=%b, want lat=%0d diff=0049 bout=0 neg=0 err=1",
                     lat, d, bo, ng, er, N + 1);
        else passed++;
        check_op("err_cleared", 16'h0005, 16'h0003, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++)
            check_op("random", int2bcd(int'($urandom_range(0, 9999))),
                     int2bcd(int'($urandom_range(0, 9999))), 1'($urandom_range(0, 1)), 1'b0);
    endtask

    // Starts in busy cycle 2 and in the DONE cycle 5 are ignored; start in cycle 6 is taken.
    task automatic test_back_to_back();
        int lat = 0;
        a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;                      // edge 0, cycle 1
        start = 1'b0;
        @(posedge clk); #1;                      // cycle 2
        a = 16'h9999; b = 16'h1111; bin = 1'b1; start = 1'b1;
        @(posedge clk); #1;                      // cycle 3
        start = 1'b0;
        @(posedge clk); #1;                      // cycle 4
        @(posedge clk); #1;                      // cycle 5: DONE
        a = 16'h8888; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        total++;
        if ({done, diff, bout, neg} !== {1'b1, 16'h0025, 2'b00})
            $display("FAIL ignore_start: got done=%b diff=%h bout=%b neg=%b, want done=1 diff=0025 bout=0 neg=0",
                     done, diff, bout, neg);
        else passed++;
        @(posedge clk); #1;                      // cycle 6: IDLE, start held
        a = 16'h0005; b = 16'h0003; bin = 1'b0;
        @(posedge clk); #1;                      // accepted at this edge
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin lat = c; break; end
        end
        total++;
        if ({8'(lat), diff, bout, neg} !== {8'(N + 1), 16'h0002, 2'b00})
            $display("FAIL idle_start: got lat=%0d diff=%h bout=%b neg=%b, want lat=%0d diff=0002 bout=0 neg=0",
                     lat, diff, bout, neg, N + 1);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int seen = 0;
        check_op("pre_abort", 16'h0017, 16'h0042, 1'b0, 1'b0);
        a = 16'h0042; b = 16'h0017; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;                      // cycle 1
        start = 1'b0;
        @(posedge clk); #1;                      // cycle 2
        @(posedge clk); #1;                      // cycle 3
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, diff, bout, neg, err} !== '0)
            $display("FAIL abort_clear: got busy=%b done=%b diff=%h bout=%b neg=%b err=%b, want all 0",
                     busy, done, diff, bout, neg, err);
        else passed++;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL abort_no_done: got %0d active cycles, want 0", seen);
        else passed++;
        @(posedge clk); #1;
        check_op("post_abort", 16'h0042, 16'h0017, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_err();
        test_random();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
